// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its prefetch FIFO.
package instr_fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP          = 32'd0;
  localparam int          IMEM_BYTES_DEFAULT = 400;
  localparam int          OPCODE_MSB         = 31;
  localparam int          OPCODE_LSB         = 26;

  // Instruction word as seen by decode and debug tooling.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] operands;
  } instr_word_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Parameterised synchronous prefetch FIFO. Flush has priority over push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage write; when full with a simultaneous pop this overwrites the
  // slot being popped, which is safe because the head is read combinationally.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clock) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches from a combinational ROM into a
// small prefetch FIFO, handles branch redirects and a sticky fetch fault.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_instruction,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instruction,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              fetch_fault
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 4);

  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        pc_plus4;
  logic                     fault;
  logic [CNT_W-1:0]         count;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic                     target_bad;
  logic                     seq_over;
  logic [DATA_W+ADDR_W-1:0] head;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign pop        = id_valid & id_ready;
  assign push       = !reset && !fault && !branch_taken && ((count < FULL_CNT) || pop);
  assign flush      = reset | branch_taken;
  assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target > LAST_ADDR);
  assign seq_over   = pc_plus4 > LAST_ADDR;

  // PC and sticky fault; a redirect wins over sequential advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (branch_taken) begin
      pc <= branch_target;
      if (target_bad) fault <= 1'b1;
    end else if (push) begin
      pc <= pc_plus4;
      if (seq_over) fault <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clock (clock),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({imem_instruction, pc_plus4}),
    .head  (head),
    .count (count)
  );

  assign imem_address = pc;
  assign fetch_fault  = fault;
  assign id_valid     = (count != '0);

  // Present a NOP bubble to decode whenever the FIFO is empty.
  always_comb begin
    id_instruction = DATA_W'(INSTR_NOP);
    id_pc_plus4    = '0;
    if (id_valid) begin
      id_instruction = head[DATA_W+ADDR_W-1:ADDR_W];
      id_pc_plus4    = head[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [0:399];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_fault;

  typedef struct {
    bit          rst;
    bit          bt;
    logic [31:0] tgt;
    bit          rdy;
    bit          ev;
    logic [31:0] epc4;
    logic [31:0] eaddr;
    bit          ef;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] idx;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      idx = a + 32'(k);
      w = {w[23:0], (idx < 32'd400) ? rom[idx] : 8'd0};
    end
    return w;
  endfunction

  assign imem_instruction = reset ? 32'd0 : rom_word(imem_address);

  instr_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_instruction   (id_instruction),
    .id_pc_plus4      (id_pc_plus4),
    .fetch_fault      (fetch_fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // clock the DUT and compare against the model.
  task automatic tick();
    logic [31:0] w;
    bit          do_pop;
    bit          do_push;
    ent_t        e;
    if (reset) begin
      mq.delete();
      m_pc    = 32'd0;
      m_fault = 1'b0;
    end else begin
      w       = rom_word(m_pc);
      do_pop  = (mq.size() > 0) && id_ready;
      do_push = !m_fault && !branch_taken && ((mq.size() < 2) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (branch_taken) begin
        mq.delete();
        if (branch_target[1:0] != 2'b00 || branch_target > 32'd396) m_fault = 1'b1;
        m_pc = branch_target;
      end else if (do_push) begin
        e.instr = w;
        e.pc4   = m_pc + 32'd4;
        mq.push_back(e);
        if (e.pc4 > 32'd396) m_fault = 1'b1;
        m_pc = e.pc4;
      end
    end
    @(posedge clock);
    #1;
    chk("model_addr",  64'(imem_address), 64'(m_pc));
    chk("model_valid", 64'(id_valid), 64'(mq.size() != 0));
    chk("model_instr", 64'(id_instruction), (mq.size() != 0) ? 64'(mq[0].instr) : 64'd0);
    chk("model_pc4",   64'(id_pc_plus4), (mq.size() != 0) ? 64'(mq[0].pc4) : 64'd0);
    chk("model_fault", 64'(fetch_fault), 64'(m_fault));
  endtask

  task automatic step(input bit rst, input bit bt, input logic [31:0] tgt, input bit rdy,
                      input bit ev, input logic [31:0] epc4, input logic [31:0] eaddr,
                      input bit ef);
    reset         = rst;
    branch_taken  = bt;
    branch_target = tgt;
    id_ready      = rdy;
    tick();
    chk("vec_addr",  64'(imem_address), 64'(eaddr));
    chk("vec_valid", 64'(id_valid), 64'(ev));
    chk("vec_instr", 64'(id_instruction), ev ? 64'(rom_word(epc4 - 32'd4)) : 64'd0);
    chk("vec_pc4",   64'(id_pc_plus4), 64'(epc4));
    chk("vec_fault", 64'(fetch_fault), 64'(ef));
  endtask

  function automatic vec_t mk(input bit rst, input bit bt, input logic [31:0] tgt, input bit rdy,
                              input bit ev, input logic [31:0] epc4, input logic [31:0] eaddr,
                              input bit ef);
    vec_t v;
    v.rst = rst; v.bt = bt; v.tgt = tgt; v.rdy = rdy;
    v.ev = ev; v.epc4 = epc4; v.eaddr = eaddr; v.ef = ef;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 400; i++) rom[i] = 8'($urandom);
    m_pc = 32'd0; m_fault = 1'b0;
    reset = 1'b1; branch_taken = 1'b0; branch_target = 32'd0; id_ready = 1'b1;

    // Reset, streaming, backpressure, and redirect while full.
    tbl.push_back(mk(1,0,0,1, 0,0,0,0));
    tbl.push_back(mk(1,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,4,4,0));
    tbl.push_back(mk(0,0,0,1, 1,8,8,0));
    tbl.push_back(mk(0,0,0,1, 1,12,12,0));
    tbl.push_back(mk(1,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,4,4,0));
    tbl.push_back(mk(0,0,0,0, 1,4,8,0));
    tbl.push_back(mk(0,0,0,0, 1,4,8,0));
    tbl.push_back(mk(0,0,0,0, 1,4,8,0));
    tbl.push_back(mk(0,0,0,0, 1,4,8,0));
    tbl.push_back(mk(0,0,0,1, 1,8,12,0));
    tbl.push_back(mk(0,0,0,1, 1,12,16,0));
    tbl.push_back(mk(0,0,0,1, 1,16,20,0));
    tbl.push_back(mk(1,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,4,4,0));
    tbl.push_back(mk(0,0,0,0, 1,4,8,0));
    tbl.push_back(mk(0,1,32'h58,1, 0,0,32'h58,0));
    tbl.push_back(mk(0,0,0,1, 1,32'h5C,32'h5C,0));
    tbl.push_back(mk(0,0,0,1, 1,32'h60,32'h60,0));

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].bt, tbl[i].tgt, tbl[i].rdy,
           tbl[i].ev, tbl[i].epc4, tbl[i].eaddr, tbl[i].ef);

    // Misaligned redirect with entries queued; faulted redirect; reset clears.
    step(1,0,0,0, 0,0,0,0);
    step(0,0,0,0, 1,4,4,0);
    step(0,0,0,0, 1,4,8,0);
    step(0,1,32'h5A,0, 0,0,32'h5A,1);
    step(0,0,0,1, 0,0,32'h5A,1);
    step(0,0,0,1, 0,0,32'h5A,1);
    step(0,1,32'h20,1, 0,0,32'h20,1);
    step(0,0,0,1, 0,0,32'h20,1);
    step(1,0,0,1, 0,0,0,0);

    // Out-of-range redirect.
    step(0,0,0,1, 1,4,4,0);
    step(0,1,32'd400,1, 0,0,32'd400,1);
    step(0,0,0,1, 0,0,32'd400,1);
    step(1,0,0,1, 0,0,0,0);

    // Sequential run off the end; queued words drain while faulted.
    step(0,1,32'd388,0, 0,0,32'd388,0);
    step(0,0,0,0, 1,32'd392,32'd392,0);
    step(0,0,0,0, 1,32'd392,32'd396,0);
    step(0,0,0,1, 1,32'd396,32'd400,1);
    step(0,0,0,1, 1,32'd400,32'd400,1);
    step(0,0,0,1, 0,0,32'd400,1);
    step(0,0,0,1, 0,0,32'd400,1);

    // Reset with two entries queued, then no stale word after release.
    step(1,0,0,0, 0,0,0,0);
    step(0,0,0,0, 1,4,4,0);
    step(0,0,0,0, 1,4,8,0);
    step(1,0,0,0, 0,0,0,0);
    step(0,0,0,1, 1,4,4,0);
    step(0,0,0,1, 1,8,8,0);

    // Back-to-back redirects: the last one wins.
    step(0,1,32'h40,1, 0,0,32'h40,0);
    step(0,1,32'h80,1, 0,0,32'h80,0);
    step(0,0,0,1, 1,32'h84,32'h84,0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset        = (r < 2);
      branch_taken = (r >= 2) && (r < 12);
      if ($urandom_range(0, 7) == 0) branch_target = 32'($urandom_range(0, 511));
      else                           branch_target = {22'd0, 8'($urandom_range(0, 99)), 2'b00};
      id_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
